// File: rtl/dmem_mmio_bridge_pkg.sv
// Memory map shared by the data-memory bridge and its timer block.
//   - MMIO base address and the register offsets inside the MMIO window
//   - TCTL bit positions
//   - address decode helpers, including the RAM-region limit check
package dmem_mmio_bridge_pkg;

  localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;
  localparam logic [31:0] OFF_LED   = 32'h0000_0000;
  localparam logic [31:0] OFF_SW    = 32'h0000_0004;
  localparam logic [31:0] OFF_TCNT  = 32'h0000_0008;
  localparam logic [31:0] OFF_TCMP  = 32'h0000_000C;
  localparam logic [31:0] OFF_TCTL  = 32'h0000_0010;

  // Word addresses (byte address >> 2). Bits [1:0] of the bus address are
  // ignored everywhere, so decode compares word addresses only.
  localparam logic [29:0] WA_LED  = 30'((MMIO_BASE + OFF_LED)  >> 2);
  localparam logic [29:0] WA_SW   = 30'((MMIO_BASE + OFF_SW)   >> 2);
  localparam logic [29:0] WA_TCNT = 30'((MMIO_BASE + OFF_TCNT) >> 2);
  localparam logic [29:0] WA_TCMP = 30'((MMIO_BASE + OFF_TCMP) >> 2);
  localparam logic [29:0] WA_TCTL = 30'((MMIO_BASE + OFF_TCTL) >> 2);

  localparam int TCTL_EN     = 0;
  localparam int TCTL_AR     = 1;
  localparam int TCTL_MATCH  = 2;
  localparam int TCTL_IRQ_EN = 3;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_LED,
    SEL_SW,
    SEL_TCNT,
    SEL_TCMP,
    SEL_TCTL
  } sel_e;

  // RAM occupies byte addresses [0, 4*words).
  function automatic logic ram_hit(input logic [31:0] addr, input int words);
    logic [32:0] lim;
    lim = 33'(words) << 2;
    return ({1'b0, addr} < lim);
  endfunction

  function automatic sel_e decode(input logic [31:0] addr, input int words);
    if (ram_hit(addr, words))         return SEL_RAM;
    else if (addr[31:2] == WA_LED)    return SEL_LED;
    else if (addr[31:2] == WA_SW)     return SEL_SW;
    else if (addr[31:2] == WA_TCNT)   return SEL_TCNT;
    else if (addr[31:2] == WA_TCMP)   return SEL_TCMP;
    else if (addr[31:2] == WA_TCTL)   return SEL_TCTL;
    else                              return SEL_NONE;
  endfunction

endpackage

// File: rtl/dmem_mmio_bridge_timer.sv
// mmio_timer: compare timer with TCNT, TCMP, TCTL registers and a registered
// interrupt output.
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   we_tcnt_i/tcmp_i/tctl_i one-cycle write strobes from the bridge decode
//   wdata_i                 store data
//   tcnt_o, tcmp_o, tctl_o  current register values for the read mux
//   irq_o                   registered MATCH & IRQ_EN
module mmio_timer
  import dmem_mmio_bridge_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_tcnt_i,
  input  logic        we_tcmp_i,
  input  logic        we_tctl_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] tcnt_o,
  output logic [31:0] tcmp_o,
  output logic [31:0] tctl_o,
  output logic        irq_o
);

  logic [31:0] tcnt_q, tcnt_d;
  logic [31:0] tcmp_q, tcmp_d;
  logic        en_q, en_d;
  logic        ar_q, ar_d;
  logic        match_q, match_d;
  logic        ie_q, ie_d;
  logic        irq_q, irq_d;
  logic        match_set;

  always_comb begin
    tcnt_d    = tcnt_q;
    tcmp_d    = tcmp_q;
    en_d      = en_q;
    ar_d      = ar_q;
    ie_d      = ie_q;
    match_set = 1'b0;

    // A CPU load of TCNT wins over counting and suppresses match detection.
    // The counter uses the EN value already registered, so a TCTL write only
    // affects counting from the following cycle.
    if (we_tcnt_i) begin
      tcnt_d = wdata_i;
    end else if (en_q) begin
      if (tcnt_q == tcmp_q) begin
        match_set = 1'b1;
        tcnt_d    = ar_q ? 32'd0 : tcnt_q + 32'd1;
      end else begin
        tcnt_d    = tcnt_q + 32'd1;
      end
    end

    if (we_tcmp_i) tcmp_d = wdata_i;

    if (we_tctl_i) begin
      en_d = wdata_i[TCTL_EN];
      ar_d = wdata_i[TCTL_AR];
      ie_d = wdata_i[TCTL_IRQ_EN];
    end

    // Set beats the write-1-to-clear on the same edge.
    match_d = match_set | (match_q & ~(we_tctl_i & wdata_i[TCTL_MATCH]));
    irq_d   = match_q & ie_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tcnt_q  <= '0;
      tcmp_q  <= '0;
      en_q    <= 1'b0;
      ar_q    <= 1'b0;
      match_q <= 1'b0;
      ie_q    <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      tcnt_q  <= tcnt_d;
      tcmp_q  <= tcmp_d;
      en_q    <= en_d;
      ar_q    <= ar_d;
      match_q <= match_d;
      ie_q    <= ie_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    tctl_o              = '0;
    tctl_o[TCTL_EN]     = en_q;
    tctl_o[TCTL_AR]     = ar_q;
    tctl_o[TCTL_MATCH]  = match_q;
    tctl_o[TCTL_IRQ_EN] = ie_q;
  end

  assign tcnt_o = tcnt_q;
  assign tcmp_o = tcmp_q;
  assign irq_o  = irq_q;

endmodule

// File: rtl/dmem_mmio_bridge.sv
// dmem_mmio_bridge: data-side memory stage behind the single-cycle core.
// Decodes the core's data address into a word-addressed RAM and an MMIO
// window (LED, synchronised switches, compare timer). Loads are combinational.
//   clk        core clock
//   rst        asynchronous active-low reset
//   MemWrite   store strobe, sampled on the rising edge
//   aluout     byte address (bits [1:0] ignored)
//   writedata  store data
//   readdata   combinational load data
//   sw_in      asynchronous switch inputs
//   led_out    LED register
//   timer_irq  registered timer interrupt
//   bus_err    sticky flag set by a store to an unmapped address
module dmem_mmio_bridge
  import dmem_mmio_bridge_pkg::*;
#(
  parameter int DM_WORDS = 1024,
  parameter int SW_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MemWrite,
  input  logic [31:0]         aluout,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  input  logic [SW_WIDTH-1:0] sw_in,
  output logic [SW_WIDTH-1:0] led_out,
  output logic                timer_irq,
  output logic                bus_err
);

  localparam int AW = $clog2(DM_WORDS);

  sel_e                sel;
  logic [AW-1:0]       ram_idx;
  logic [31:0]         mem_q [DM_WORDS];
  logic [SW_WIDTH-1:0] led_q, led_d;
  logic [SW_WIDTH-1:0] sw_s1_q, sw_s2_q;
  logic                bus_err_q, bus_err_d;
  logic [31:0]         tcnt, tcmp, tctl;

  assign sel     = decode(aluout, DM_WORDS);
  assign ram_idx = aluout[AW+1:2];

  // RAM contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (MemWrite && (sel == SEL_RAM)) mem_q[ram_idx] <= writedata;
  end

  always_comb begin
    led_d     = led_q;
    bus_err_d = bus_err_q;
    if (MemWrite && (sel == SEL_LED))  led_d     = writedata[SW_WIDTH-1:0];
    if (MemWrite && (sel == SEL_NONE)) bus_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q     <= '0;
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      led_q     <= led_d;
      sw_s1_q   <= sw_in;
      sw_s2_q   <= sw_s1_q;
      bus_err_q <= bus_err_d;
    end
  end

  mmio_timer u_timer (
    .clk_i     (clk),
    .rst_ni    (rst),
    .we_tcnt_i (MemWrite && (sel == SEL_TCNT)),
    .we_tcmp_i (MemWrite && (sel == SEL_TCMP)),
    .we_tctl_i (MemWrite && (sel == SEL_TCTL)),
    .wdata_i   (writedata),
    .tcnt_o    (tcnt),
    .tcmp_o    (tcmp),
    .tctl_o    (tctl),
    .irq_o     (timer_irq)
  );

  always_comb begin
    readdata = 32'd0;
    case (sel)
      SEL_RAM:  readdata = mem_q[ram_idx];
      SEL_LED:  readdata = 32'(led_q);
      SEL_SW:   readdata = 32'(sw_s2_q);
      SEL_TCNT: readdata = tcnt;
      SEL_TCMP: readdata = tcmp;
      SEL_TCTL: readdata = tctl;
      default:  readdata = 32'd0;
    endcase
  end

  assign led_out = led_q;
  assign bus_err = bus_err_q;

endmodule

// File: doc/dmem_mmio_bridge.md
Name: dmem_mmio_bridge

Overview:
Data-side memory stage directly downstream of the single-cycle CPU core. It consumes the core's data address (aluout), MemWrite and writedata, and returns readdata combinationally in the same cycle. It decodes the address into a word-addressed data RAM and a small MMIO window holding an LED register, a synchronised switch input and a compare timer with an interrupt flag.

Parameters:
DM_WORDS, 1024, data RAM depth in 32-bit words (power of two, at most 1024).
SW_WIDTH, 16, width of the switch input and of the LED output.

Ports:
clk  input  1  core clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset.
MemWrite  input  1  write strobe from the core, sampled at the rising edge.
aluout  input  32  byte address from the core; bits [1:0] are ignored.
writedata  input  32  store data from the core.
readdata  output  32  combinational load data for the current address.
sw_in  input  SW_WIDTH  asynchronous board switches.
led_out  output  SW_WIDTH  LED register, driven directly from the flop.
timer_irq  output  1  registered MATCH AND IRQ_EN.
bus_err  output  1  sticky flag: an unmapped address was written.

Behaviour:
- Address map (word aligned):
  - 0x0000_0000 to 4*DM_WORDS-1: RAM, index aluout[log2(DM_WORDS)+1:2].
  - 0xFFFF_0000 LED: read/write, low SW_WIDTH bits used.
  - 0xFFFF_0004 SW: read-only, zero-extended.
  - 0xFFFF_0008 TCNT: read/write.
  - 0xFFFF_000C TCMP: read/write.
  - 0xFFFF_0010 TCTL bits:
    - bit0 EN, read/write.
    - bit1 AUTO_RELOAD, read/write.
    - bit2 MATCH, sticky, write-1-to-clear.
    - bit3 IRQ_EN, read/write.
    - all other bits read as 0.
  - Every other address is unmapped.
- Reads are purely combinational from the current register and RAM state, with zero latency. An unmapped read returns 0x0000_0000.
- Writes take effect at the rising edge when MemWrite=1 and are visible on readdata in the next cycle.
  - A write to SW is ignored.
  - An unmapped write is ignored and sets bus_err. bus_err clears only on reset.
- RAM: synchronous write, asynchronous read. RAM contents are not reset and are undefined until written.
- Reset (rst=0, asynchronous assert, synchronous-safe release) clears to 0: led_out, TCNT, TCMP, TCTL, bus_err, timer_irq, and both synchroniser stages.
- SW path: two-flop synchroniser. A change on sw_in is visible at 0xFFFF_0004 after exactly 2 rising edges.
- Timer, evaluated every edge, in priority order:
  1. CPU write to TCNT loads writedata. A load suppresses both increment and match evaluation in that cycle.
  2. Otherwise, if EN=1 and TCNT==TCMP:
     - set MATCH;
     - next TCNT = 0 if AUTO_RELOAD=1, else TCNT+1.
  3. Otherwise, if EN=1: TCNT = TCNT+1, wrapping 0xFFFF_FFFF to 0 with no flag.
  4. If EN=0, TCNT holds.
- MATCH set and a W1C clear in the same cycle: set wins, so MATCH stays 1.
- A TCTL write updates EN, AUTO_RELOAD and IRQ_EN in the same edge as the W1C. The new EN value takes effect from the following cycle.
- timer_irq is registered: it asserts one cycle after MATCH and IRQ_EN are both 1, and deasserts one cycle after either clears.
- A reset asserted mid-count zeroes the timer immediately. There are no stale interrupts after reset release.

Decomposition:
- Shared package (memory map), holding:
  - the MMIO base 0xFFFF_0000 and the register offsets 0x0, 0x4, 0x8, 0xC, 0x10;
  - the TCTL bit indices (EN=0, AUTO_RELOAD=1, MATCH=2, IRQ_EN=3);
  - the RAM-region decode limit.
- One sub-module, mmio_timer, containing TCNT, TCMP, TCTL and timer_irq with their write ports. Address decode, RAM, LED, SW synchroniser and the readdata mux stay in the top level.

Test Plan:
- RAM round trip:
  - write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 -> 0xDEADBEEF the next cycle;
  - read 0x0000_0013 -> 0xDEADBEEF, because the low bits are ignored.
- LED/SW:
  - write 0x0001_A5A5 to 0xFFFF_0000 -> led_out=0xA5A5;
  - set sw_in=0x1234 -> 0xFFFF_0004 reads 0 after 1 edge and 0x0000_1234 after 2 edges;
  - writing 0xFFFF_0004 leaves it unchanged.
- Timer match, auto-reload:
  - write TCMP=5, then TCTL=0xB (EN, AUTO_RELOAD, IRQ_EN);
  - expect TCNT sequence 0,1,2,3,4,5,0 with MATCH=1 from the edge at TCNT=5;
  - expect timer_irq=1 one cycle later;
  - write TCTL=0xF (W1C) -> MATCH=0 and timer_irq drops the next cycle.
- Simultaneous events:
  - TCNT load of 0x10 on the same edge as an increment -> TCNT=0x10;
  - W1C on the same edge as a new match -> MATCH remains 1;
  - TCNT=0xFFFF_FFFF, TCMP=0, AUTO_RELOAD=0 -> wraps to 0 with no MATCH that edge, then matches at 0.
- Unmapped access:
  - read 0x8000_0000 -> 0, bus_err stays 0;
  - write 0x8000_0000 -> bus_err=1, and it holds through later valid accesses until rst=0.
- Async reset mid-run:
  - with the timer running and IRQ asserted, pulse rst low between clock edges;
  - outputs go to 0 immediately, without waiting for an edge;
  - after release, TCNT stays 0 because EN=0, and RAM contents written before reset still read back.
